// File: rtl/tlb_ctrl_pkg.sv
// Op codes, controller state encoding and parameter helpers for the CP0 TLB op controller.
package tlb_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_TLBP  = 2'd0,
    OP_TLBR  = 2'd1,
    OP_TLBWI = 2'd2,
    OP_TLBWR = 2'd3
  } TLBOp;

  typedef enum logic [2:0] {
    CTRL_IDLE  = 3'd0,
    CTRL_PROBE = 3'd1,
    CTRL_READ  = 3'd2,
    CTRL_WRITE = 3'd3,
    CTRL_DONE  = 3'd4
  } CtrlState;

  // One full sweep of the TLB groups plus two cycles of pipeline slack.
  function automatic int probe_timeout_default(input int num_entries, input int group_size);
    return num_entries / group_size + 2;
  endfunction

endpackage

// File: rtl/tlb_types_pkg.sv
// Shared TLB data types used by the TLB top and its controllers.
package tlb_types_pkg;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic [15:0] pagemask;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } TLBEntry;

endpackage

// File: rtl/mips32r2_tlb_random.sv
// CP0 Random register: counts down from NUM_ENTRIES-1 to Wired, reloading on Wired writes.
module mips32r2_tlb_random #(
  parameter int NUM_ENTRIES = 64,
  localparam int IDX_W = $clog2(NUM_ENTRIES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] wired,
  input  logic             wired_we,
  input  logic             freeze,
  output logic [IDX_W-1:0] random
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_ENTRIES - 1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      random <= MAX_IDX;
    end else if (wired_we || (wired >= MAX_IDX)) begin
      random <= MAX_IDX;
    end else if (freeze) begin
      random <= random;
    end else if ((random == wired) || (random == '0)) begin
      random <= MAX_IDX;
    end else begin
      random <= random - IDX_W'(1);
    end
  end

endmodule

// File: rtl/mips32r2_tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR onto the TLB probe/read/write ports, one op at a time.
// Optional macro TLB_OP_STATS_EN adds saturating probe/write/timeout counters.
module mips32r2_tlb_op_ctrl
  import tlb_ctrl_pkg::*, tlb_types_pkg::*;
#(
  parameter int NUM_ENTRIES   = 64,
  parameter int GROUP_SIZE    = 4,
  parameter int PROBE_TIMEOUT = probe_timeout_default(NUM_ENTRIES, GROUP_SIZE),
  localparam int IDX_W = $clog2(NUM_ENTRIES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  output logic             op_ready,
  input  logic [18:0]      cp0_vpn2,
  input  logic [7:0]       cp0_asid,
  input  logic [IDX_W-1:0] cp0_index,
  input  TLBEntry          cp0_entry,
  input  logic [IDX_W-1:0] wired,
  input  logic             wired_we,
  output logic [IDX_W-1:0] t_r_index,
  input  logic             t_r_ready,
  input  TLBEntry          t_r_resp,
  output logic             t_w_valid,
  output logic [IDX_W-1:0] t_w_index,
  output TLBEntry          t_w_data,
  input  logic             t_w_ready,
  output logic             t_p_valid,
  output logic [18:0]      t_p_ivpn2,
  output logic [7:0]       t_p_iasid,
  input  logic             t_p_ready,
  input  logic             t_p_miss,
  input  logic [IDX_W-1:0] t_p_index,
  output logic             done,
  output logic             res_miss,
  output logic [IDX_W-1:0] res_index,
  output TLBEntry          res_entry,
  output logic             res_timeout,
  output logic [IDX_W-1:0] random
`ifdef TLB_OP_STATS_EN
  ,
  output logic [31:0]      stat_probes,
  output logic [31:0]      stat_probe_miss,
  output logic [31:0]      stat_writes,
  output logic [31:0]      stat_timeouts
`endif
);

  localparam logic [2:0] IDLE  = CTRL_IDLE;
  localparam logic [2:0] PROBE = CTRL_PROBE;
  localparam logic [2:0] READ  = CTRL_READ;
  localparam logic [2:0] WRITE = CTRL_WRITE;
  localparam logic [2:0] DONE  = CTRL_DONE;

  localparam int CNT_W = $clog2(PROBE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(PROBE_TIMEOUT - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] probe_cnt;
  logic             probe_timed_out;
  logic             probe_end;
  logic             rand_freeze;

  assign op_ready        = (state == IDLE);
  assign done            = (state == DONE);
  assign probe_timed_out = (state == PROBE) && !t_p_ready && !t_p_miss && (probe_cnt == TIMEOUT_LAST);
  assign probe_end       = (state == PROBE) && (t_p_ready || t_p_miss || probe_timed_out);

  // Freezing on the accepting edge too keeps Random equal to the latched TLBWR index.
  assign rand_freeze = (state == WRITE) || (op_ready && op_valid && op_code[1]);

  mips32r2_tlb_random #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_random (
    .clock   (clock),
    .reset   (reset),
    .wired   (wired),
    .wired_we(wired_we),
    .freeze  (rand_freeze),
    .random  (random)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      probe_cnt   <= '0;
      t_r_index   <= '0;
      t_w_valid   <= 1'b0;
      t_w_index   <= '0;
      t_w_data    <= '0;
      t_p_valid   <= 1'b0;
      t_p_ivpn2   <= '0;
      t_p_iasid   <= '0;
      res_miss    <= 1'b0;
      res_index   <= '0;
      res_entry   <= '0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            case (op_code)
              OP_TLBP: begin
                state       <= PROBE;
                probe_cnt   <= '0;
                t_p_valid   <= 1'b1;
                t_p_ivpn2   <= cp0_vpn2;
                t_p_iasid   <= cp0_asid;
                res_timeout <= 1'b0;
              end
              OP_TLBR: begin
                state     <= READ;
                t_r_index <= cp0_index;
              end
              default: begin
                state     <= WRITE;
                t_w_valid <= 1'b1;
                t_w_index <= (op_code == OP_TLBWR) ? random : cp0_index;
                t_w_data  <= cp0_entry;
              end
            endcase
          end
        end
        PROBE: begin
          probe_cnt <= probe_cnt + CNT_W'(1);
          if (t_p_ready) begin
            res_miss  <= 1'b0;
            res_index <= t_p_index;
          end else if (t_p_miss || probe_timed_out) begin
            res_miss    <= 1'b1;
            res_timeout <= probe_timed_out;
          end
          if (probe_end) begin
            state     <= DONE;
            t_p_valid <= 1'b0;
            t_p_ivpn2 <= '0;
            t_p_iasid <= '0;
          end
        end
        READ: begin
          if (t_r_ready) begin
            state     <= DONE;
            res_entry <= t_r_resp;
            t_r_index <= '0;
          end
        end
        WRITE: begin
          if (t_w_ready) begin
            state     <= DONE;
            t_w_valid <= 1'b0;
            t_w_index <= '0;
            t_w_data  <= '0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TLB_OP_STATS_EN
  logic probe_accept;
  logic probe_miss_end;
  logic write_end;

  assign probe_accept   = op_ready && op_valid && (op_code == OP_TLBP);
  assign probe_miss_end = probe_end && !t_p_ready;
  assign write_end      = (state == WRITE) && t_w_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_probes     <= '0;
      stat_probe_miss <= '0;
      stat_writes     <= '0;
      stat_timeouts   <= '0;
    end else begin
      if (probe_accept && (stat_probes != '1))
        stat_probes <= stat_probes + 32'd1;
      if (probe_miss_end && (stat_probe_miss != '1))
        stat_probe_miss <= stat_probe_miss + 32'd1;
      if (write_end && (stat_writes != '1))
        stat_writes <= stat_writes + 32'd1;
      if (probe_timed_out && (stat_timeouts != '1))
        stat_timeouts <= stat_timeouts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips32r2_tlb_op_ctrl.sv
// Scoreboard bench for mips32r2_tlb_op_ctrl: expected results are queued at issue and popped on done.
module tb_mips32r2_tlb_op_ctrl;
  import tlb_types_pkg::*;

  localparam int IDX_W = 6;

  typedef struct packed {
    logic             miss;
    logic [IDX_W-1:0] index;
    logic             timeout;
    TLBEntry          entry;
  } exp_t;

  logic             clock;
  logic             reset;
  logic             op_valid;
  logic [1:0]       op_code;
  logic             op_ready;
  logic [18:0]      cp0_vpn2;
  logic [7:0]       cp0_asid;
  logic [IDX_W-1:0] cp0_index;
  TLBEntry          cp0_entry;
  logic [IDX_W-1:0] wired;
  logic             wired_we;
  logic [IDX_W-1:0] t_r_index;
  logic             t_r_ready;
  TLBEntry          t_r_resp;
  logic             t_w_valid;
  logic [IDX_W-1:0] t_w_index;
  TLBEntry          t_w_data;
  logic             t_w_ready;
  logic             t_p_valid;
  logic [18:0]      t_p_ivpn2;
  logic [7:0]       t_p_iasid;
  logic             t_p_ready;
  logic             t_p_miss;
  logic [IDX_W-1:0] t_p_index;
  logic             done;
  logic             res_miss;
  logic [IDX_W-1:0] res_index;
  TLBEntry          res_entry;
  logic             res_timeout;
  logic [IDX_W-1:0] random;
`ifdef TLB_OP_STATS_EN
  logic [31:0] stat_probes, stat_probe_miss, stat_writes, stat_timeouts;
`endif

  int vectors = 0;
  int miscompares = 0;

  int p_run, p_hit_at, p_miss_at, w_run, w_ready_at, r_run, r_ready_at;
  logic r_active;
  logic [IDX_W-1:0] p_idx;
  TLBEntry r_data;

  exp_t exp_q[$];
  logic [IDX_W-1:0] rand_q[$];
  exp_t e;
  logic m_miss, m_timeout;
  logic [IDX_W-1:0] m_index;
  TLBEntry m_entry;

  mips32r2_tlb_op_ctrl dut (
    .clock(clock), .reset(reset),
    .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .cp0_vpn2(cp0_vpn2), .cp0_asid(cp0_asid), .cp0_index(cp0_index), .cp0_entry(cp0_entry),
    .wired(wired), .wired_we(wired_we),
    .t_r_index(t_r_index), .t_r_ready(t_r_ready), .t_r_resp(t_r_resp),
    .t_w_valid(t_w_valid), .t_w_index(t_w_index), .t_w_data(t_w_data), .t_w_ready(t_w_ready),
    .t_p_valid(t_p_valid), .t_p_ivpn2(t_p_ivpn2), .t_p_iasid(t_p_iasid),
    .t_p_ready(t_p_ready), .t_p_miss(t_p_miss), .t_p_index(t_p_index),
    .done(done), .res_miss(res_miss), .res_index(res_index), .res_entry(res_entry),
    .res_timeout(res_timeout), .random(random)
`ifdef TLB_OP_STATS_EN
    , .stat_probes(stat_probes), .stat_probe_miss(stat_probe_miss),
    .stat_writes(stat_writes), .stat_timeouts(stat_timeouts)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic TLBEntry make_entry(input int seed);
    TLBEntry x;
    x = '0;
    x.vpn2 = 19'(seed * 977);
    x.asid = 8'(seed);
    x.g    = seed[0];
    x.pfn0 = 20'(seed * 31 + 1);
    x.c0   = 3'd3;
    x.v0   = 1'b1;
    x.pfn1 = 20'(seed * 57 + 2);
    x.c1   = 3'd2;
    x.d1   = 1'b1;
    x.v1   = 1'b1;
    return x;
  endfunction

  // Advance to the next falling edge and play the TLB's side of the handshakes.
  task automatic step_cycle();
    @(negedge clock);
    if (t_p_valid) p_run++; else p_run = 0;
    t_p_ready = (p_hit_at != 0) && t_p_valid && (p_run == p_hit_at);
    t_p_miss  = (p_miss_at != 0) && t_p_valid && (p_run == p_miss_at);
    t_p_index = t_p_ready ? p_idx : '0;
    if (t_w_valid) w_run++; else w_run = 0;
    t_w_ready = (w_ready_at != 0) && t_w_valid && (w_run == w_ready_at);
    if (r_active) r_run++;
    t_r_ready = r_active && (r_ready_at != 0) && (r_run == r_ready_at);
    t_r_resp  = t_r_ready ? r_data : '0;
    if (t_r_ready) r_active = 1'b0;
  endtask

  task automatic run_op(input int bound, output int done_at, output int pv);
    done_at = 0;
    pv = 0;
    for (int c = 1; c <= bound; c++) begin
      step_cycle();
      op_valid = 1'b0;
      if (t_p_valid) pv++;
      if (done) begin
        done_at = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [IDX_W-1:0] exp_r;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    vectors++; if (random !== 6'd63) begin miscompares++; $display("[TB] FAIL reset_random: got %0d expected 63", random); end
    vectors++; if (op_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_op_ready: got %b expected 1", op_ready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    vectors++; if ({t_p_valid, t_w_valid, t_r_index} !== '0) begin miscompares++; $display("[TB] FAIL reset_tlb_ports: got %b/%b/%0d expected 0", t_p_valid, t_w_valid, t_r_index); end
    vectors++; if ({res_miss, res_timeout, res_index} !== '0) begin miscompares++; $display("[TB] FAIL reset_res: got %b/%b/%0d expected 0", res_miss, res_timeout, res_index); end
    vectors++; if (res_entry !== '0) begin miscompares++; $display("[TB] FAIL reset_res_entry: got %h expected 0", res_entry); end
    for (int k = 1; k <= 70; k++) begin
      rand_q.push_back(IDX_W'(63 - (k % 64)));
      step_cycle();
      exp_r = rand_q.pop_front();
      vectors++; if (random !== exp_r) begin miscompares++; $display("[TB] FAIL idle_random cycle %0d: got %0d expected %0d", k, random, exp_r); end
    end
    vectors++; if (op_ready !== 1'b1 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_status: got ready=%b done=%b expected ready=1 done=0", op_ready, done); end
  endtask

  task automatic test_probe_hit();
    int done_at, pv;
    p_hit_at = 4; p_miss_at = 0; p_idx = 6'd17;
    op_valid = 1'b1; op_code = 2'd0; cp0_vpn2 = 19'h1234; cp0_asid = 8'd5;
    m_miss = 1'b0; m_index = 6'd17; m_timeout = 1'b0;
    exp_q.push_back('{m_miss, m_index, m_timeout, m_entry});
    step_cycle();
    op_valid = 1'b0;
    vectors++; if (t_p_valid !== 1'b1 || op_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL probe_issue: got valid=%b ready=%b expected valid=1 ready=0", t_p_valid, op_ready); end
    vectors++; if (t_p_ivpn2 !== 19'h1234 || t_p_iasid !== 8'd5) begin miscompares++; $display("[TB] FAIL probe_key: got %h/%0d expected 1234/5", t_p_ivpn2, t_p_iasid); end
    run_op(40, done_at, pv);
    vectors++; if (done_at + 1 !== 5) begin miscompares++; $display("[TB] FAIL probe_hit_done_cycle: got %0d expected 5", done_at + 1); end
    vectors++; if (pv + 1 !== 4) begin miscompares++; $display("[TB] FAIL probe_hit_valid_cycles: got %0d expected 4", pv + 1); end
    e = exp_q.pop_front();
    vectors++; if (res_miss !== e.miss || res_index !== e.index || res_timeout !== e.timeout) begin miscompares++; $display("[TB] FAIL probe_hit_result: got %b/%0d/%b expected %b/%0d/%b", res_miss, res_index, res_timeout, e.miss, e.index, e.timeout); end
    step_cycle();
    vectors++; if (done !== 1'b0 || op_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL probe_done_pulse: got done=%b ready=%b expected 0/1", done, op_ready); end
  endtask

  task automatic test_probe_timeout();
    int done_at, pv;
    p_hit_at = 0; p_miss_at = 0;
    op_valid = 1'b1; op_code = 2'd0; cp0_vpn2 = 19'h7ffff; cp0_asid = 8'haa;
    m_miss = 1'b1; m_timeout = 1'b1;
    exp_q.push_back('{m_miss, m_index, m_timeout, m_entry});
    step_cycle();
    op_valid = 1'b0;
    run_op(60, done_at, pv);
    vectors++; if (pv + 1 !== 18) begin miscompares++; $display("[TB] FAIL timeout_valid_cycles: got %0d expected 18", pv + 1); end
    vectors++; if (done_at + 1 !== 19) begin miscompares++; $display("[TB] FAIL timeout_done_cycle: got %0d expected 19", done_at + 1); end
    e = exp_q.pop_front();
    vectors++; if (res_miss !== e.miss || res_index !== e.index || res_timeout !== e.timeout) begin miscompares++; $display("[TB] FAIL timeout_result: got %b/%0d/%b expected %b/%0d/%b", res_miss, res_index, res_timeout, e.miss, e.index, e.timeout); end
    step_cycle();
  endtask

  task automatic test_probe_miss();
    int done_at, pv;
    p_hit_at = 0; p_miss_at = 2;
    op_valid = 1'b1; op_code = 2'd0; cp0_vpn2 = 19'h00042; cp0_asid = 8'd1;
    m_miss = 1'b1; m_timeout = 1'b0;
    exp_q.push_back('{m_miss, m_index, m_timeout, m_entry});
    run_op(40, done_at, pv);
    vectors++; if (done_at !== 3) begin miscompares++; $display("[TB] FAIL miss_done_cycle: got %0d expected 3", done_at); end
    e = exp_q.pop_front();
    vectors++; if (res_miss !== e.miss || res_index !== e.index || res_timeout !== e.timeout) begin miscompares++; $display("[TB] FAIL miss_result: got %b/%0d/%b expected %b/%0d/%b", res_miss, res_index, res_timeout, e.miss, e.index, e.timeout); end
    step_cycle();
    // Hit and miss in the same cycle: the hit must win.
    p_hit_at = 3; p_miss_at = 3; p_idx = 6'd42;
    op_valid = 1'b1; op_code = 2'd0;
    m_miss = 1'b0; m_index = 6'd42; m_timeout = 1'b0;
    exp_q.push_back('{m_miss, m_index, m_timeout, m_entry});
    run_op(40, done_at, pv);
    vectors++; if (done_at !== 4) begin miscompares++; $display("[TB] FAIL priority_done_cycle: got %0d expected 4", done_at); end
    e = exp_q.pop_front();
    vectors++; if (res_miss !== e.miss || res_index !== e.index || res_timeout !== e.timeout) begin miscompares++; $display("[TB] FAIL priority_result: got %b/%0d/%b expected %b/%0d/%b", res_miss, res_index, res_timeout, e.miss, e.index, e.timeout); end
    step_cycle();
  endtask

  task automatic test_write_random();
    int done_at, wv;
    logic found;
    TLBEntry wentry;
    found = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (random == 6'd40) begin found = 1'b1; break; end
      step_cycle();
    end
    vectors++; if (found !== 1'b1) begin miscompares++; $display("[TB] FAIL tlbwr_wait_random: got %0d expected 40", random); end
    wentry = make_entry(5);
    w_ready_at = 3;
    op_valid = 1'b1; op_code = 2'd3; cp0_index = 6'd3; cp0_entry = wentry;
    exp_q.push_back('{m_miss, m_index, m_timeout, m_entry});
    done_at = 0; wv = 0;
    for (int c = 1; c <= 20; c++) begin
      step_cycle();
      op_valid = 1'b0;
      if (t_w_valid) begin
        wv++;
        vectors++; if (t_w_index !== 6'd40 || t_w_data !== wentry) begin miscompares++; $display("[TB] FAIL tlbwr_port cycle %0d: got idx=%0d data=%h expected idx=40 data=%h", c, t_w_index, t_w_data, wentry); end
        vectors++; if (random !== 6'd40) begin miscompares++; $display("[TB] FAIL tlbwr_random_frozen cycle %0d: got %0d expected 40", c, random); end
      end
      if (done) begin done_at = c; break; end
    end
    vectors++; if (wv !== 3 || done_at !== 4) begin miscompares++; $display("[TB] FAIL tlbwr_timing: got valid=%0d done=%0d expected 3/4", wv, done_at); end
    vectors++; if (random !== 6'd40) begin miscompares++; $display("[TB] FAIL tlbwr_random_at_done: got %0d expected 40", random); end
    e = exp_q.pop_front();
    vectors++; if (res_miss !== e.miss || res_index !== e.index || res_entry !== e.entry) begin miscompares++; $display("[TB] FAIL tlbwr_res_kept: got %b/%0d expected %b/%0d", res_miss, res_index, e.miss, e.index); end
    step_cycle();
    vectors++; if (random !== 6'd39) begin miscompares++; $display("[TB] FAIL tlbwr_random_resume: got %0d expected 39", random); end
  endtask

  task automatic test_write_indexed();
    int done_at, pv;
    TLBEntry wentry;
    wentry = make_entry(9);
    w_ready_at = 1;
    op_valid = 1'b1; op_code = 2'd2; cp0_index = 6'd22; cp0_entry = wentry;
    step_cycle();
    op_valid = 1'b0;
    vectors++; if (t_w_valid !== 1'b1 || t_w_index !== 6'd22 || t_w_data !== wentry) begin miscompares++; $display("[TB] FAIL tlbwi_port: got v=%b idx=%0d data=%h expected v=1 idx=22 data=%h", t_w_valid, t_w_index, t_w_data, wentry); end
    run_op(20, done_at, pv);
    vectors++; if (done_at + 1 !== 2) begin miscompares++; $display("[TB] FAIL tlbwi_done_cycle: got %0d expected 2", done_at + 1); end
    step_cycle();
  endtask

  task automatic test_wired();
    logic found;
    logic [IDX_W-1:0] exp_r;
    found = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (random == 6'd10) begin found = 1'b1; break; end
      step_cycle();
    end
    vectors++; if (found !== 1'b1) begin miscompares++; $display("[TB] FAIL wired_wait_random: got %0d expected 10", random); end
    wired = 6'd60; wired_we = 1'b1;
    rand_q.push_back(6'd63); rand_q.push_back(6'd62); rand_q.push_back(6'd61);
    rand_q.push_back(6'd60); rand_q.push_back(6'd63); rand_q.push_back(6'd62);
    for (int k = 0; k < 6; k++) begin
      step_cycle();
      wired_we = 1'b0;
      exp_r = rand_q.pop_front();
      vectors++; if (random !== exp_r) begin miscompares++; $display("[TB] FAIL wired60_random step %0d: got %0d expected %0d", k, random, exp_r); end
    end
    wired = 6'd63; wired_we = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step_cycle();
      wired_we = 1'b0;
      vectors++; if (random !== 6'd63) begin miscompares++; $display("[TB] FAIL wired63_hold step %0d: got %0d expected 63", k, random); end
    end
    wired = 6'd0; wired_we = 1'b1;
    step_cycle();
    wired_we = 1'b0;
    step_cycle();
    vectors++; if (random !== 6'd62) begin miscompares++; $display("[TB] FAIL wired0_resume: got %0d expected 62", random); end
  endtask

  task automatic test_read_reset();
    logic saw_done;
    op_valid = 1'b1; op_code = 2'd1; cp0_index = 6'd9;
    r_active = 1'b1; r_run = 0; r_ready_at = 0;
    step_cycle();
    op_valid = 1'b0;
    vectors++; if (t_r_index !== 6'd9 || op_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL tlbr_issue: got idx=%0d ready=%b expected 9/0", t_r_index, op_ready); end
    step_cycle();
    vectors++; if (t_r_index !== 6'd9) begin miscompares++; $display("[TB] FAIL tlbr_hold: got %0d expected 9", t_r_index); end
    #2 reset = 1'b0;
    #1;
    r_active = 1'b0; r_run = 0;
    m_miss = 1'b0; m_index = '0; m_timeout = 1'b0; m_entry = '0;
    vectors++; if (t_r_index !== '0 || t_p_valid !== 1'b0 || t_w_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midop_reset_ports: got idx=%0d pv=%b wv=%b expected 0", t_r_index, t_p_valid, t_w_valid); end
    vectors++; if (op_ready !== 1'b1 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL midop_reset_state: got ready=%b done=%b expected 1/0", op_ready, done); end
    vectors++; if (res_entry !== m_entry || random !== 6'd63) begin miscompares++; $display("[TB] FAIL midop_reset_regs: got entry=%h random=%0d expected 0/63", res_entry, random); end
    @(negedge clock);
    reset = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step_cycle();
      if (done) saw_done = 1'b1;
    end
    vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("[TB] FAIL midop_no_done: got %b expected 0", saw_done); end
  endtask

  task automatic test_read_normal();
    int done_at, pv;
    r_data = make_entry(21);
    op_valid = 1'b1; op_code = 2'd1; cp0_index = 6'd9;
    r_active = 1'b1; r_run = 0; r_ready_at = 2;
    m_entry = r_data;
    exp_q.push_back('{m_miss, m_index, m_timeout, m_entry});
    run_op(20, done_at, pv);
    vectors++; if (done_at !== 3) begin miscompares++; $display("[TB] FAIL tlbr_done_cycle: got %0d expected 3", done_at); end
    e = exp_q.pop_front();
    vectors++; if (res_entry !== e.entry || res_miss !== e.miss || res_index !== e.index) begin miscompares++; $display("[TB] FAIL tlbr_result: got %h expected %h", res_entry, e.entry); end
    step_cycle();
  endtask

  task automatic test_back_to_back();
    int first_done, second_done;
    p_hit_at = 1; p_miss_at = 0; p_idx = 6'd33;
    op_valid = 1'b1; op_code = 2'd0; cp0_vpn2 = 19'h00abc; cp0_asid = 8'd7;
    m_miss = 1'b0; m_index = 6'd33; m_timeout = 1'b0;
    exp_q.push_back('{m_miss, m_index, m_timeout, m_entry});
    exp_q.push_back('{m_miss, m_index, m_timeout, m_entry});
    first_done = 0; second_done = 0;
    for (int c = 1; c <= 8; c++) begin
      step_cycle();
      if (c >= 4) op_valid = 1'b0;
      if (c == 2) begin
        vectors++; if (op_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_ready_in_done: got %b expected 0", op_ready); end
      end
      if (c == 3) begin
        vectors++; if (op_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_ready_idle: got %b expected 1", op_ready); end
      end
      if (done) begin
        if (first_done == 0) first_done = c; else second_done = c;
        e = exp_q.pop_front();
        vectors++; if (res_miss !== e.miss || res_index !== e.index) begin miscompares++; $display("[TB] FAIL b2b_result cycle %0d: got %b/%0d expected %b/%0d", c, res_miss, res_index, e.miss, e.index); end
      end
    end
    vectors++; if (first_done !== 2 || second_done !== 5) begin miscompares++; $display("[TB] FAIL b2b_done_cycles: got %0d/%0d expected 2/5", first_done, second_done); end
    vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  initial begin
    reset = 1'b0;
    op_valid = 1'b0; op_code = 2'd0;
    cp0_vpn2 = '0; cp0_asid = '0; cp0_index = '0; cp0_entry = '0;
    wired = '0; wired_we = 1'b0;
    t_r_ready = 1'b0; t_r_resp = '0; t_w_ready = 1'b0;
    t_p_ready = 1'b0; t_p_miss = 1'b0; t_p_index = '0;
    p_run = 0; p_hit_at = 0; p_miss_at = 0; p_idx = '0;
    w_run = 0; w_ready_at = 0; r_run = 0; r_ready_at = 0; r_active = 1'b0; r_data = '0;
    m_miss = 1'b0; m_index = '0; m_timeout = 1'b0; m_entry = '0;

    test_reset();
    test_probe_hit();
    test_probe_timeout();
    test_probe_miss();
    test_write_random();
    test_write_indexed();
    test_wired();
    test_read_reset();
    test_read_normal();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips32r2_tlb_op_ctrl.md
Name: mips32r2_tlb_op_ctrl

Overview:
Sequences the CP0 TLB instructions TLBP, TLBR, TLBWI and TLBWR onto the TLB's read, write and probe ports, one operation at a time.
Maintains the Random register and a probe timeout backstop.
Sits between the CP0/execute stage and the TLB top, and owns the TLB's r_index, w_* and p_* ports.

Parameters:
NUM_ENTRIES, 64, number of TLB entries; IDX_W = $clog2(NUM_ENTRIES)
GROUP_SIZE, 4, entries searched per probe cycle by the TLB
PROBE_TIMEOUT, NUM_ENTRIES/GROUP_SIZE+2, cycles in PROBE before the controller forces a miss

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
op_valid  in  1  operation request
op_code  in  2  0=TLBP 1=TLBR 2=TLBWI 3=TLBWR
op_ready  out  1  controller can accept an op
cp0_vpn2  in  19  EntryHi.VPN2 for TLBP
cp0_asid  in  8  EntryHi.ASID for TLBP
cp0_index  in  IDX_W  Index for TLBR/TLBWI
cp0_entry  in  TLBEntry  write data for TLBWI/TLBWR
wired  in  IDX_W  Wired register value
wired_we  in  1  Wired being written this cycle
t_r_index  out  IDX_W  TLB read index
t_r_ready  in  1  TLB read data valid
t_r_resp  in  TLBEntry  TLB read data
t_w_valid  out  1  TLB write request
t_w_index  out  IDX_W  TLB write index
t_w_data  out  TLBEntry  TLB write data
t_w_ready  in  1  TLB write accepted
t_p_valid  out  1  TLB probe request
t_p_ivpn2  out  19  probe VPN2
t_p_iasid  out  8  probe ASID
t_p_ready  in  1  probe hit
t_p_miss  in  1  probe miss
t_p_index  in  IDX_W  hit index
done  out  1  one-cycle completion pulse
res_miss  out  1  TLBP result: no match (Index.P)
res_index  out  IDX_W  TLBP hit index
res_entry  out  TLBEntry  TLBR data
res_timeout  out  1  probe ended by timeout
random  out  IDX_W  Random register

Behaviour:
- Reset values: all outputs 0, except random = NUM_ENTRIES-1 and op_ready = 1. The state machine resets to IDLE.
- States: IDLE, PROBE, READ, WRITE, DONE.
- IDLE:
  - op_ready = 1.
  - When op_valid is high, latch op_code, all cp0_* inputs and random (the TLBWR index).
  - Next state: PROBE for TLBP, READ for TLBR, WRITE for TLBWI/TLBWR.
- op_ready = 0 in every state other than IDLE. There is no back-to-back accept: the minimum op period is 3 cycles.
- PROBE:
  - t_p_valid = 1, driving the latched vpn2/asid.
  - t_p_ready (hit) has priority over t_p_miss. On hit, capture t_p_index and set res_miss = 0.
  - On t_p_miss, set res_miss = 1.
  - If the timeout counter reaches PROBE_TIMEOUT, set res_miss = 1 and res_timeout = 1.
  - Any of these three events goes to DONE. The counter clears on entry to PROBE.
- READ:
  - t_r_index = latched index, held until t_r_ready.
  - On t_r_ready, capture t_r_resp into res_entry and go to DONE.
- WRITE:
  - t_w_valid = 1, t_w_index = latched index (TLBWI) or latched random (TLBWR), t_w_data = latched entry.
  - All held stable until t_w_ready, then go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- res_* outputs hold their values until the next completion of the same operation type. res_timeout clears on the next TLBP accept.
- Random:
  - Decrements every cycle.
  - When random == wired (or == 0), the next value is NUM_ENTRIES-1.
  - If wired >= NUM_ENTRIES-1, random is held at NUM_ENTRIES-1.
  - wired_we forces NUM_ENTRIES-1 the next cycle, overriding the decrement.
  - Random freezes while in WRITE, so a TLBWR index never matches a live write.
- Outputs are registered, except op_ready and done, which decode from state.
- Asserting reset mid-operation returns to IDLE immediately and deasserts t_*_valid. The partially issued op is dropped, with no done pulse.

Optional Feature:
Macro TLB_OP_STATS_EN.
- Defined: adds 32-bit saturating output counters stat_probes, stat_probe_miss, stat_writes and stat_timeouts.
  - stat_probes counts TLBP accepts; stat_probe_miss counts probe completions with res_miss = 1.
  - stat_writes counts WRITE completions; stat_timeouts counts timeout-terminated probes.
  - All counters reset to 0.
- Undefined: the counter ports and logic are absent.

Decomposition:
- Package tlb_ctrl_pkg:
  - TLBOp enum (TLBP/TLBR/TLBWI/TLBWR);
  - CtrlState enum;
  - PROBE_TIMEOUT default helper function.
- TLBEntry is reused from the existing TLB types header.
- One sub-module, mips32r2_tlb_random, holds the Random register: inputs wired, wired_we and freeze; output random.

Test Plan:
- Reset then idle for 70 cycles with wired=0 -> random reads 63,62,...,0,63; op_ready=1; done=0.
- TLBP vpn2=0x1234 asid=5, TLB raises t_p_ready with t_p_index=17 after 4 cycles -> done pulses 1 cycle later; res_miss=0; res_index=17; t_p_valid high exactly 4 cycles.
- TLBP with t_p_ready and t_p_miss never asserted -> t_p_valid high for PROBE_TIMEOUT (18) cycles, then done=1, res_miss=1, res_timeout=1.
- TLBWR with random=40 at accept and t_w_ready delayed 3 cycles -> t_w_index=40 stable for all 3 cycles, random frozen at 40 throughout, done follows.
- wired_we with wired=60 while random=10 -> random=63,62,61,60, then 63 again.
- TLBR index=9, then assert reset in READ before t_r_ready -> t_r_* idle, state IDLE, op_ready=1, no done pulse, res_entry unchanged (0).
